// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared CPU types for the fetch front end
package inst_fetch_pkg;

  typedef logic [15:0] inst_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// rtl/inst_fetch_pc_reg.sv - program counter register, load beats increment
module pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] q
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign q = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch FSM, instruction register and next-PC select
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [15:0]       rom_data,
  output inst_word_t        inst,
  output logic              inst_valid,
  input  logic              inst_ack,
  input  logic              jmp_if,
  input  logic [ADDR_W-1:0] A,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  inst_word_t        r_inst;
  logic              w_fetch_done;
  logic              w_exec;
  logic [ADDR_W-1:0] w_pc;

  // Handshakes only count in the state that expects them.
  assign w_fetch_done = (r_state == FETCH) && rom_valid;
  assign w_exec       = (r_state == HOLD) && inst_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = FETCH;
      FETCH:   if (rom_valid) w_next_state = HOLD;
      HOLD:    if (inst_ack) w_next_state = FETCH;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst <= '0;
    end else if (w_fetch_done) begin
      r_inst <= rom_data;
    end
  end

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_exec && jmp_if),
    .load_val (A),
    .inc      (w_exec && !jmp_if),
    .q        (w_pc)
  );

  assign rom_req    = (r_state == FETCH);
  assign rom_addr   = w_pc;
  assign inst_valid = (r_state == HOLD);
  assign inst       = r_inst;
  assign pc         = w_pc;

endmodule
